// File: rtl/block_code_pkg.sv
// Shared types and helpers for the RM(1,m) soft-decision decoder.
package block_code_pkg;

   // Frame life cycle: wait for first symbol, fill buffer, correlate, publish.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_CORR    = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   // Smallest usable code order; m=0 would be a one-symbol repetition code.
   localparam int M_MIN = 1;

   // Walsh/Hadamard entry sign: 1 when row i is negated at column j.
   function automatic logic walsh_neg(input logic [15:0] i, input logic [15:0] j);
      return ^(i & j);
   endfunction

   // True when a requested code order can be handled by a buffer built for max_m.
   function automatic logic m_is_legal(input logic [3:0] m, input int max_m);
      return (int'(m) >= M_MIN) && (int'(m) <= max_m);
   endfunction

endpackage

// File: rtl/rm_symbol_buffer.sv
// Soft-symbol frame store: synchronous write port, combinational read port.
module rm_symbol_buffer #(
   parameter int DATA_WIDTH = 4,
   parameter int ADDR_W     = 5
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

   // Store one symbol per accepted write; contents need no reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/rm1_soft_decoder.sv
// RM(1,m) soft decoder: buffers N=2^m symbols, correlates serially against
// every Walsh row (one MAC per clock) and reports the strongest row.
module rm1_soft_decoder
   import block_code_pkg::*;
#(
   parameter int DATA_WIDTH = 4,
   parameter int MAX_M      = 5
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DATA_WIDTH-1:0]       rx_symbols,
   input  logic                        rx_symbols_valid,
   input  logic [3:0]                  code_length,
   output logic                        rx_ready,
   output logic                        rx_overrun,
   output logic [MAX_M:0]              dec_data,
   output logic [DATA_WIDTH+MAX_M-1:0] dec_metric,
   output logic                        dec_valid,
   output logic                        dec_error
);

   localparam int ACC_W = DATA_WIDTH + MAX_M + 1;
   localparam int MET_W = DATA_WIDTH + MAX_M;
   localparam logic [MAX_M-1:0] IDX_ONE = 1;

   state_t                  state_q, state_d;
   logic [3:0]              m_q, m_d;
   logic [MAX_M-1:0]        wr_cnt_q, wr_cnt_d;
   logic [MAX_M-1:0]        row_q, row_d;
   logic [MAX_M-1:0]        col_q, col_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [MET_W-1:0]        best_mag_q, best_mag_d;
   logic [MAX_M-1:0]        best_row_q, best_row_d;
   logic                    best_neg_q, best_neg_d;
   logic [MAX_M:0]          dec_data_q, dec_data_d;
   logic [MET_W-1:0]        dec_metric_q, dec_metric_d;
   logic                    dec_valid_q, dec_valid_d;
   logic                    dec_error_q, dec_error_d;
   logic                    rx_overrun_q, rx_overrun_d;

   logic [MAX_M-1:0]        n_last;
   logic                    buf_wr_en;
   logic [MAX_M-1:0]        buf_wr_addr;
   logic [DATA_WIDTH-1:0]   buf_rd_data;
   logic signed [ACC_W-1:0] sym_ext;
   logic signed [ACC_W-1:0] acc_sum;
   logic [ACC_W-1:0]        acc_mag;
   logic                    ready_int;

   rm_symbol_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_W     (MAX_M)
   ) u_buffer (
      .clk     (clk),
      .wr_en   (buf_wr_en),
      .wr_addr (buf_wr_addr),
      .wr_data (rx_symbols),
      .rd_addr (col_q),
      .rd_data (buf_rd_data)
   );

   // Last valid index N-1 for the latched code order (m low bits set).
   always_comb begin
      n_last = '0;
      for (int k = 0; k < MAX_M; k++) begin
         n_last[k] = (k < int'(m_q));
      end
   end

   // One MAC step: add or subtract the buffered symbol per the Walsh sign.
   always_comb begin
      sym_ext = {{(ACC_W-DATA_WIDTH){buf_rd_data[DATA_WIDTH-1]}}, buf_rd_data};
      acc_sum = walsh_neg(16'(row_q), 16'(col_q)) ? (acc_q - sym_ext) : (acc_q + sym_ext);
      acc_mag = acc_sum[ACC_W-1] ? -acc_sum : acc_sum;
   end

   assign ready_int = (state_q == ST_IDLE) || (state_q == ST_COLLECT);

   // Frame control, correlation bookkeeping and result publication.
   always_comb begin
      state_d      = state_q;
      m_d          = m_q;
      wr_cnt_d     = wr_cnt_q;
      row_d        = row_q;
      col_d        = col_q;
      acc_d        = acc_q;
      best_mag_d   = best_mag_q;
      best_row_d   = best_row_q;
      best_neg_d   = best_neg_q;
      dec_data_d   = dec_data_q;
      dec_metric_d = dec_metric_q;
      dec_valid_d  = 1'b0;
      dec_error_d  = 1'b0;
      rx_overrun_d = rx_symbols_valid && !ready_int;
      buf_wr_en    = 1'b0;
      buf_wr_addr  = wr_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (rx_symbols_valid) begin
               if (m_is_legal(code_length, MAX_M)) begin
                  m_d         = code_length;
                  buf_wr_en   = 1'b1;
                  buf_wr_addr = '0;
                  wr_cnt_d    = IDX_ONE;
                  state_d     = ST_COLLECT;
               end else begin
                  dec_error_d = 1'b1;
               end
            end
         end
         ST_COLLECT: begin
            if (rx_symbols_valid) begin
               buf_wr_en = 1'b1;
               if (wr_cnt_q == n_last) begin
                  wr_cnt_d = '0;
                  row_d    = '0;
                  col_d    = '0;
                  acc_d    = '0;
                  state_d  = ST_CORR;
               end else begin
                  wr_cnt_d = wr_cnt_q + IDX_ONE;
               end
            end
         end
         ST_CORR: begin
            acc_d = acc_sum;
            col_d = col_q + IDX_ONE;
            if (col_q == n_last) begin
               col_d = '0;
               acc_d = '0;
               // Strictly-greater update keeps the lowest row on ties.
               if ((row_q == '0) || (acc_mag > {1'b0, best_mag_q})) begin
                  best_mag_d = acc_mag[MET_W-1:0];
                  best_row_d = row_q;
                  best_neg_d = acc_sum[ACC_W-1];
               end
               if (row_q == n_last) begin
                  state_d = ST_DONE;
               end else begin
                  row_d = row_q + IDX_ONE;
               end
            end
         end
         ST_DONE: begin
            dec_data_d   = {best_row_q, best_neg_q};
            dec_metric_d = best_mag_q;
            dec_valid_d  = 1'b1;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         m_q          <= '0;
         wr_cnt_q     <= '0;
         row_q        <= '0;
         col_q        <= '0;
         acc_q        <= '0;
         best_mag_q   <= '0;
         best_row_q   <= '0;
         best_neg_q   <= 1'b0;
         dec_data_q   <= '0;
         dec_metric_q <= '0;
         dec_valid_q  <= 1'b0;
         dec_error_q  <= 1'b0;
         rx_overrun_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         m_q          <= m_d;
         wr_cnt_q     <= wr_cnt_d;
         row_q        <= row_d;
         col_q        <= col_d;
         acc_q        <= acc_d;
         best_mag_q   <= best_mag_d;
         best_row_q   <= best_row_d;
         best_neg_q   <= best_neg_d;
         dec_data_q   <= dec_data_d;
         dec_metric_q <= dec_metric_d;
         dec_valid_q  <= dec_valid_d;
         dec_error_q  <= dec_error_d;
         rx_overrun_q <= rx_overrun_d;
      end
   end

   assign rx_ready   = ready_int;
   assign rx_overrun = rx_overrun_q;
   assign dec_data   = dec_data_q;
   assign dec_metric = dec_metric_q;
   assign dec_valid  = dec_valid_q;
   assign dec_error  = dec_error_q;

endmodule
